// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
//   NIBBLE   : slice width processed per RUN cycle
//   state_t  : controller states (IDLE / RUN / DONE)
//   clog2()  : counter width helper for the nibble counter
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle of the nibble-serial adder.
//   start/sub/a/b                       : request, driven by the master (ALU decode)
//   busy/done/sum/carry_out/overflow/zero: response, driven by the slave (adder)
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow, zero
    );

endinterface

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead slice (CLA_UNIT).
//   i_a, i_b : nibble operands
//   i_c      : carry in
//   o_s      : nibble sum
//   o_c      : carry out of bit 3
module nibble_serial_adder_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;
        w_c[0] = i_c;
        w_c[1] = w_g[0] | (w_p[0] & i_c);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_c);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
        o_s = w_p ^ w_c[3:0];
        o_c = w_c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine using one 4-bit CLA slice.
// Operands are latched on an accepted start, then one nibble per cycle
// (LSB first) is added with a registered carry. Result and flags are
// published together on the last RUN edge and held until the next
// operation completes.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : request/response bundle (slave side)
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);

    localparam int unsigned N     = WIDTH / NIBBLE;
    localparam int unsigned CNT_W = clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    // Holds the N-1 nibbles already produced, newest at the top.
    logic [WIDTH-5:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_next;

    nibble_serial_adder_cla u_cla (
        .i_a (r_a[3:0]),
        .i_b (r_b[3:0]),
        .i_c (r_c),
        .o_s (w_s),
        .o_c (w_c)
    );

    assign w_accept   = bus.start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    assign w_sum_next = {w_s, r_acc};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state == S_RUN);
        bus.done      = (r_state == S_DONE);
        bus.sum       = r_sum;
        bus.carry_out = r_carry;
        bus.overflow  = r_ovf;
        bus.zero      = r_zero;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction as a + ~b + 1: the +1 enters through the carry.
            r_a   <= bus.a;
            r_b   <= bus.sub ? ~bus.b : bus.b;
            r_c   <= bus.sub;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= {4'b0000, r_a[WIDTH-1:4]};
            r_b   <= {4'b0000, r_b[WIDTH-1:4]};
            r_c   <= w_c;
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_sum_next[WIDTH-1:4];
            if (w_last) begin
                r_sum   <= w_sum_next;
                r_carry <= w_c;
                // Carry into bit 3 (a^b^s) differs from carry out of it.
                r_ovf   <= r_a[3] ^ r_b[3] ^ w_s[3] ^ w_c;
                r_zero  <= (w_sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int unsigned dcyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    exp_t        q[$];

    nibble_serial_adder_if #(.WIDTH(32)) bus ();

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_sum"},  bus.sum,              e.sum);
                chk({e.name, "_co"},   {31'd0, bus.carry_out}, {31'd0, e.co});
                chk({e.name, "_ov"},   {31'd0, bus.overflow},  {31'd0, e.ov});
                chk({e.name, "_zero"}, {31'd0, bus.zero},      {31'd0, e.z});
                chk({e.name, "_lat"},  cyc,                  e.dcyc);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
    endtask

    task automatic push(input string name, input logic [31:0] es, input logic eco,
                        input logic eov, input logic ez);
        exp_t e;
        e.sum = es; e.co = eco; e.ov = eov; e.z = ez;
        e.dcyc = cyc + 9;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] es, input logic eco,
                      input logic eov, input logic ez);
        @(negedge clk);
        drive(a, b, s);
        push(name, es, eco, eov, ez);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned budget;
        budget = 0;
        while (q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget = budget + 1;
        end
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, {31'd0, bus.busy},      32'd0);
        chk({name, "_done"}, {31'd0, bus.done},      32'd0);
        chk({name, "_sum"},  bus.sum,                32'd0);
        chk({name, "_co"},   {31'd0, bus.carry_out}, 32'd0);
        chk({name, "_ov"},   {31'd0, bus.overflow},  32'd0);
        chk({name, "_zero"}, {31'd0, bus.zero},      32'd0);
    endtask

    initial begin
        int unsigned budget;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b1;

        // Leave a nonzero result behind, then abort a 5+3 mid-RUN with reset.
        op("pre", 32'h0000_0011, 32'h0000_0022, 1'b0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        drain("pre");
        @(negedge clk);
        drive(32'd5, 32'd3, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("abort");
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_idle_sum",  bus.sum,           32'd0);

        op("add9",   32'h0000_0009, 32'h0000_0000, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        drain("add9");
        op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain("ripple");
        op("sub33",  32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain("sub33");
        op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        drain("subovf");
        op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drain("addovf");
        op("borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        drain("borrow");

        // Mid-RUN start ignored; start in DONE runs back-to-back.
        op("hs1", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        drive(32'd100, 32'd100, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        budget = 0;
        while (bus.done !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget = budget + 1;
        end
        chk("hs1_done_seen", {31'd0, bus.done}, 32'd1);
        drive(32'd3, 32'd3, 1'b0);
        push("hs2", 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("hs_hold_sum", bus.sum, 32'h0000_0003);
        end
        drain("hs2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
